if_neuron_bank: RTL and testbench

- Time-multiplexed bank of N integrate-and-fire neurons holding per-neuron membrane potential and post-spike count in internal registers.
- Successor to the single combinational IF neuron update: generalises widths and neuron count.
- Adds event backpressure, a sequential fire/leak sweep per time step, selectable reset mode, saturating arithmetic and a registered readback port.
- Sits between the synaptic event router (input) and the spike encoder/learning unit (output).

---
 rtl/if_neuron_bank.sv | 127 ++++++++++++
 tb/tb_if_neuron_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_neuron_bank.sv
// if_neuron_bank: time-multiplexed bank of integrate-and-fire neurons with event input, fire/leak sweep and readback
// Ports: param_thr/param_leak/cfg_reset_sub configure the neuron; ev_* is the synaptic event input with ready;
// time_step_event starts a sweep, time_ref_event clears all state; spike_* and sweep_done report sweep results;
// step_overrun flags a step that arrived mid-sweep; rd_addr selects the neuron shown on rd_pot/rd_cnt.
module if_neuron_bank #(
  parameter int N_NEURON = 256,
  parameter int ADDR_W   = 8,
  parameter int POT_W    = 12,
  parameter int WGT_W    = 8,
  parameter int CNT_W    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [POT_W-1:0] param_thr,
  input  logic [POT_W-1:0]        param_leak,
  input  logic                    cfg_reset_sub,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic [ADDR_W-1:0]       ev_addr,
  input  logic signed [WGT_W-1:0] ev_weight,
  input  logic                    time_step_event,
  input  logic                    time_ref_event,
  output logic                    spike_valid,
  output logic [ADDR_W-1:0]       spike_addr,
  output logic                    sweep_done,
  output logic                    step_overrun,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic signed [POT_W-1:0] rd_pot,
  output logic [CNT_W-1:0]        rd_cnt
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, spike_addr_q, spike_addr_d;
  logic signed [POT_W-1:0] pot_q [N_NEURON];
  logic signed [POT_W-1:0] pot_d [N_NEURON];
  logic [CNT_W-1:0] cnt_q [N_NEURON];
  logic [CNT_W-1:0] cnt_d [N_NEURON];
  logic ready_q, spike_valid_q, spike_valid_d, sweep_done_q, sweep_done_d, step_overrun_q, step_overrun_d;
  logic signed [POT_W-1:0] rd_pot_q, rd_pot_d, cur, ev_pot;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic signed [POT_W:0] cur_x, leak_x, leak_val, ev_sum;
  logic fire, last, ev_in_range;
  assign ev_ready = ready_q && state_q == IDLE && !time_ref_event && !time_step_event;
  assign ev_in_range = int'(ev_addr) < N_NEURON;
  always_comb begin
    cur = pot_q[idx_q];
    cur_x = (POT_W+1)'(cur);
    leak_x = {1'b0, param_leak};
    fire = cur >= param_thr;
    last = idx_q == ADDR_W'(N_NEURON-1);
    // one extra bit so -(-2^(POT_W-1)) and the overflowing event sum stay representable
    leak_val = cur[POT_W-1] ? ((-cur_x > leak_x) ? cur_x + leak_x : '0) : ((cur_x > leak_x) ? cur_x - leak_x : '0);
    ev_sum = (POT_W+1)'(pot_q[ev_addr]) + (POT_W+1)'(ev_weight);
    ev_pot = (ev_sum[POT_W] != ev_sum[POT_W-1]) ? {ev_sum[POT_W], {(POT_W-1){~ev_sum[POT_W]}}} : ev_sum[POT_W-1:0];
    state_d = state_q;
    idx_d = idx_q;
    pot_d = pot_q;
    cnt_d = cnt_q;
    spike_valid_d = 1'b0;
    spike_addr_d = spike_addr_q;
    sweep_done_d = 1'b0;
    step_overrun_d = step_overrun_q;
    if (time_ref_event) begin
      state_d = IDLE;
      idx_d = '0;
      pot_d = '{default: '0};
      cnt_d = '{default: '0};
      step_overrun_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (time_step_event) begin
        state_d = SWEEP;
        idx_d = '0;
      end else if (ev_valid && ev_ready && ev_in_range) begin
        pot_d[ev_addr] = ev_pot;
      end
    end else begin
      step_overrun_d = step_overrun_q | time_step_event;
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? IDLE : SWEEP;
      sweep_done_d = last;
      if (fire) begin
        spike_valid_d = 1'b1;
        spike_addr_d = idx_q;
        cnt_d[idx_q] = &cnt_q[idx_q] ? cnt_q[idx_q] : cnt_q[idx_q] + 1'b1;
        pot_d[idx_q] = cfg_reset_sub ? cur - param_thr : '0;
      end else begin
        pot_d[idx_q] = leak_val[POT_W-1:0];
      end
    end
    // readback shows the value being committed on this edge
    rd_pot_d = pot_d[rd_addr];
    rd_cnt_d = cnt_d[rd_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      pot_q <= '{default: '0};
      cnt_q <= '{default: '0};
      ready_q <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_addr_q <= '0;
      sweep_done_q <= 1'b0;
      step_overrun_q <= 1'b0;
      rd_pot_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pot_q <= pot_d;
      cnt_q <= cnt_d;
      ready_q <= 1'b1;
      spike_valid_q <= spike_valid_d;
      spike_addr_q <= spike_addr_d;
      sweep_done_q <= sweep_done_d;
      step_overrun_q <= step_overrun_d;
      rd_pot_q <= rd_pot_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
  assign spike_valid = spike_valid_q;
  assign spike_addr = spike_addr_q;
  assign sweep_done = sweep_done_q;
  assign step_overrun = step_overrun_q;
  assign rd_pot = rd_pot_q;
  assign rd_cnt = rd_cnt_q;
endmodule

// File: tb/tb_if_neuron_bank.sv
// tb_if_neuron_bank: directed self-checking bench for if_neuron_bank with a 16-neuron bank
module tb_if_neuron_bank;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [11:0] param_thr = 12'sd10;
  logic [11:0] param_leak = '0;
  logic cfg_reset_sub = 1'b1;
  logic ev_valid = 1'b0;
  logic ev_ready;
  logic [3:0] ev_addr = '0;
  logic signed [7:0] ev_weight = '0;
  logic time_step_event = 1'b0;
  logic time_ref_event = 1'b0;
  logic spike_valid;
  logic [3:0] spike_addr;
  logic sweep_done;
  logic step_overrun;
  logic [3:0] rd_addr = '0;
  logic signed [11:0] rd_pot;
  logic [6:0] rd_cnt;
  int checks = 0;
  int errors = 0;
  logic [15:0] mask;
  int busy, spikes, dones;
  if_neuron_bank #(.N_NEURON(N), .ADDR_W(4), .POT_W(12), .WGT_W(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .param_thr(param_thr), .param_leak(param_leak), .cfg_reset_sub(cfg_reset_sub),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_weight(ev_weight),
    .time_step_event(time_step_event), .time_ref_event(time_ref_event),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .sweep_done(sweep_done), .step_overrun(step_overrun),
    .rd_addr(rd_addr), .rd_pot(rd_pot), .rd_cnt(rd_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] a, input logic signed [7:0] w);
    ev_valid = 1'b1;
    ev_addr = a;
    ev_weight = w;
    tick();
    ev_valid = 1'b0;
  endtask
  task automatic read(input logic [3:0] a, input int p, input int c);
    rd_addr = a;
    tick();
    check("rd_pot", rd_pot, p);
    check("rd_cnt", rd_cnt, c);
  endtask
  task automatic ref_clear;
    time_ref_event = 1'b1;
    tick();
    time_ref_event = 1'b0;
  endtask
  task automatic run_sweep(output logic [15:0] m);
    time_step_event = 1'b1;
    tick();
    time_step_event = 1'b0;
    m = '0;
    for (int j = 1; j <= N; j++) begin
      tick();
      if (spike_valid) begin
        m[spike_addr] = 1'b1;
        check("spike_addr", spike_addr, j - 1);
      end
      check("sweep_done", sweep_done, j == N);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tick();
    check("rst_ready", ev_ready, 0);
    check("rst_spike", spike_valid, 0);
    check("rst_done", sweep_done, 0);
    check("rst_overrun", step_overrun, 0);
    check("rst_rdpot", rd_pot, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", ev_ready, 1);
    // reset in the middle of a sweep
    send(4'd1, 8'sd20);
    rd_addr = 4'd1;
    time_step_event = 1'b1;
    tick();
    time_step_event = 1'b0;
    tick();
    tick();
    check("mid_spike", spike_valid, 1);
    check("mid_spike_addr", spike_addr, 1);
    check("mid_rdpot", rd_pot, 10);
    check("mid_rdcnt", rd_cnt, 1);
    rst = 1'b1;
    #1;
    check("ar_spike", spike_valid, 0);
    check("ar_addr", spike_addr, 0);
    check("ar_done", sweep_done, 0);
    check("ar_overrun", step_overrun, 0);
    check("ar_rdpot", rd_pot, 0);
    check("ar_rdcnt", rd_cnt, 0);
    check("ar_ready", ev_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_ready_rel", ev_ready, 1);
    for (int i = 0; i < N; i++) read(4'(i), 0, 0);
    // integrate and fire, subtract mode
    send(4'd3, 8'sd5);
    send(4'd3, 8'sd4);
    send(4'd3, 8'sd4);
    read(4'd3, 13, 0);
    run_sweep(mask);
    check("if_mask", mask, 16'h0008);
    read(4'd3, 3, 1);
    read(4'd0, 0, 0);
    // reset-to-zero and leak
    ref_clear();
    cfg_reset_sub = 1'b0;
    param_leak = 12'd2;
    send(4'd0, 8'sd12);
    send(4'd1, -8'sd3);
    send(4'd2, 8'sd5);
    run_sweep(mask);
    check("lk_mask1", mask, 16'h0001);
    read(4'd0, 0, 1);
    read(4'd1, -1, 0);
    read(4'd2, 3, 0);
    run_sweep(mask);
    check("lk_mask2", mask, 16'h0000);
    read(4'd1, 0, 0);
    read(4'd2, 1, 0);
    read(4'd0, 0, 1);
    // saturation of potential and count
    ref_clear();
    param_leak = '0;
    cfg_reset_sub = 1'b1;
    for (int i = 0; i < 20; i++) send(4'd5, 8'sd127);
    read(4'd5, 2047, 0);
    for (int i = 0; i < 40; i++) send(4'd5, -8'sd128);
    read(4'd5, -2048, 0);
    ref_clear();
    param_thr = 12'sd1;
    for (int i = 0; i < 17; i++) send(4'd6, 8'sd127);
    read(4'd6, 2047, 0);
    for (int i = 0; i < 127; i++) run_sweep(mask);
    read(4'd6, 1920, 127);
    for (int i = 0; i < 3; i++) run_sweep(mask);
    read(4'd6, 1917, 127);
    // backpressure and overrun
    ref_clear();
    param_thr = 12'sd10;
    check("ov_clear", step_overrun, 0);
    time_step_event = 1'b1;
    tick();
    time_step_event = 1'b0;
    ev_valid = 1'b1;
    ev_addr = 4'd2;
    ev_weight = 8'sd7;
    busy = 0;
    while (!ev_ready && busy < 50) begin
      busy++;
      time_step_event = (busy == 3);
      tick();
      time_step_event = 1'b0;
    end
    check("bp_cycles", busy, N);
    check("ov_set", step_overrun, 1);
    tick();
    ev_valid = 1'b0;
    read(4'd2, 7, 0);
    tick();
    tick();
    check("one_sweep_ready", ev_ready, 1);
    check("ov_sticky", step_overrun, 1);
    // simultaneous ref and step with nonzero state
    send(4'd4, 8'sd30);
    run_sweep(mask);
    check("pre_mask", mask, 16'h0010);
    read(4'd4, 20, 1);
    time_ref_event = 1'b1;
    time_step_event = 1'b1;
    tick();
    time_ref_event = 1'b0;
    time_step_event = 1'b0;
    check("sim_overrun", step_overrun, 0);
    spikes = 0;
    dones = 0;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      spikes += int'(spike_valid);
      dones += int'(sweep_done);
    end
    check("sim_spikes", spikes, 0);
    check("sim_dones", dones, 0);
    check("sim_ready", ev_ready, 1);
    for (int i = 0; i < N; i++) read(4'(i), 0, 0);
    // ref aborting a sweep produces no sweep_done
    send(4'd0, 8'sd30);
    time_step_event = 1'b1;
    tick();
    time_step_event = 1'b0;
    tick();
    tick();
    tick();
    ref_clear();
    dones = 0;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      dones += int'(sweep_done);
    end
    check("abort_dones", dones, 0);
    read(4'd0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
